// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank read-out engine.
// Holds the FSM state encoding and the width helpers that size the bit
// counter (0..WIDTH, WIDTH being the parity slot) and the register index.
package reg_bank_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must reach WIDTH itself (the parity slot).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Register index width, never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_reader_if.sv
// Serial output stream of the register-bank reader.
//   sout       : serial data bit
//   sout_valid : sout holds a valid bit
//   sout_ready : consumer accepts the bit on valid & ready
//   sout_par   : current bit is a parity bit
//   sout_last  : current bit is the last bit of the transfer
// master = reader side, slave = consumer side.
interface reg_bank_reader_if;
  logic sout;
  logic sout_valid;
  logic sout_ready;
  logic sout_par;
  logic sout_last;

  modport master (
    output sout, sout_valid, sout_par, sout_last,
    input  sout_ready
  );

  modport slave (
    input  sout, sout_valid, sout_par, sout_last,
    output sout_ready
  );
endinterface

// File: rtl/reg_bank_reader_frame_serializer.sv
// frame_serializer: emits one WIDTH-bit word LSB first followed by an
// even-parity bit, one bit per valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   load       : capture word and present its bit 0 next cycle (wins over
//                the end-of-frame handshake so frames can run back to back)
//   word       : word to serialize
//   last_in    : this word is the final frame of the transfer
//   ready      : consumer ready
//   sout/valid/par/last : registered stream outputs
//   eof        : handshake on the parity bit (end of frame), combinational
module frame_serializer
  import reg_bank_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             last_in,
  input  logic             ready,
  output logic             sout,
  output logic             valid,
  output logic             par,
  output logic             last,
  output logic             eof
);

  localparam int CW = cnt_w(WIDTH);

  // Remaining data bits; bit 0 is already on sout when a word is loaded.
  logic [WIDTH-2:0] sh;
  logic [CW-1:0]    bit_cnt;
  logic             par_bit;
  logic             last_frame;

  assign eof = valid & ready & par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      last_frame <= 1'b0;
      sout       <= 1'b0;
      valid      <= 1'b0;
      par        <= 1'b0;
      last       <= 1'b0;
    end else if (load) begin
      sh         <= word[WIDTH-1:1];
      sout       <= word[0];
      par_bit    <= ^word;
      last_frame <= last_in;
      bit_cnt    <= '0;
      valid      <= 1'b1;
      par        <= 1'b0;
      last       <= 1'b0;
    end else if (valid && ready) begin
      if (par) begin
        // Parity accepted and no follow-on frame: drop the stream.
        valid   <= 1'b0;
        par     <= 1'b0;
        last    <= 1'b0;
        sout    <= 1'b0;
        bit_cnt <= '0;
      end else if (bit_cnt == CW'(WIDTH - 1)) begin
        sout    <= par_bit;
        par     <= 1'b1;
        last    <= last_frame;
        bit_cnt <= CW'(WIDTH);
      end else begin
        sout    <= sh[0];
        sh      <= sh >> 1;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: snapshots a DEPTH x WIDTH register bank on start and
// streams it bit-serially (LSB first, even parity after each register).
//   C, CLRbar : clock, async active-low reset
//   start     : read-out request, honoured in IDLE only
//   bank_q    : register i at bits [i*WIDTH +: WIDTH]
//   sif       : serial stream (master side)
//   cur_idx   : index of the register being sent
//   busy      : snapshot through the done cycle
//   done      : one-cycle pulse after the final bit is accepted
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     C,
  input  logic                     CLRbar,
  input  logic                     start,
  input  logic [DEPTH*WIDTH-1:0]   bank_q,
  reg_bank_reader_if.master        sif,
  output logic [idx_w(DEPTH)-1:0]  cur_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = idx_w(DEPTH);

  state_t                 state, state_next;
  logic [DEPTH*WIDTH-1:0] snap;
  logic [IW-1:0]          nxt_idx;
  logic [IW-1:0]          load_idx;
  logic [WIDTH-1:0]       snap_word;
  logic [WIDTH-1:0]       load_word;
  logic                   load;
  logic                   load_last;
  logic                   last_frame;
  logic                   eof;

  assign nxt_idx    = cur_idx + IW'(1);
  assign last_frame = (cur_idx == IW'(DEPTH - 1));
  assign load_last  = (load_idx == IW'(DEPTH - 1));

  // Next register out of the snapshot.
  always_comb begin
    snap_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (nxt_idx == IW'(i)) snap_word = snap[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge C or negedge CLRbar) begin
    if (!CLRbar) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_idx   = '0;
    // Register 0 is taken straight from the bank on the snapshot edge.
    load_word  = bank_q[WIDTH-1:0];
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (eof) begin
          if (last_frame) begin
            state_next = DONE;
          end else begin
            load      = 1'b1;
            load_idx  = nxt_idx;
            load_word = snap_word;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge CLRbar) begin
    if (!CLRbar) begin
      snap    <= '0;
      cur_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (state == IDLE && start) snap <= bank_q;
      if (load) cur_idx <= load_idx;
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

  frame_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk     (C),
    .rst_n   (CLRbar),
    .load    (load),
    .word    (load_word),
    .last_in (load_last),
    .ready   (sif.sout_ready),
    .sout    (sif.sout),
    .valid   (sif.sout_valid),
    .par     (sif.sout_par),
    .last    (sif.sout_last),
    .eof     (eof)
  );

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader (WIDTH=8, DEPTH=4). A queue-based model turns
// each accepted start into the expected list of (bit, parity, last, index)
// entries; one negedge process compares the DUT against it every cycle.
module tb_reg_bank_reader;

  localparam int W = 8;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_XFER = 1, M_DONE = 2;

  typedef struct packed {
    logic       b;
    logic       p;
    logic       l;
    logic [1:0] idx;
  } ent_t;

  logic           C = 1'b0;
  logic           CLRbar;
  logic           start;
  logic [D*W-1:0] bank_q;
  logic [1:0]     cur_idx;
  logic           busy, done;

  reg_bank_reader_if sif();

  reg_bank_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .C       (C),
    .CLRbar  (CLRbar),
    .start   (start),
    .bank_q  (bank_q),
    .sif     (sif),
    .cur_idx (cur_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 C = ~C;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge C) cyc++;

  // ---------------- behavioural model ----------------
  ent_t exp_q[$];
  int   m_phase = M_IDLE;

  always @(posedge C or negedge CLRbar) begin
    if (!CLRbar) begin
      exp_q.delete();
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (start) begin
          for (int r = 0; r < D; r++) begin
            logic [W-1:0] w;
            ent_t e;
            w = bank_q[r*W +: W];
            for (int b = 0; b < W; b++) begin
              e = '{b: w[b], p: 1'b0, l: 1'b0, idx: 2'(r)};
              exp_q.push_back(e);
            end
            e = '{b: ^w, p: 1'b1, l: (r == D-1), idx: 2'(r)};
            exp_q.push_back(e);
          end
          m_phase = M_XFER;
        end
        M_XFER: if (sif.sout_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // ---------------- compare / capture ----------------
  int          hs_cnt;
  logic [35:0] cap_bits;
  int          last_pos;
  int          done_cyc;
  int          snap_cyc;

  always @(negedge C) begin
    if (!CLRbar) begin
      chk("reset_outputs",
          {sif.sout, sif.sout_valid, sif.sout_par, sif.sout_last, cur_idx, busy, done}, 0);
    end else begin
      chk("valid", sif.sout_valid, m_phase == M_XFER);
      chk("busy",  busy,           m_phase != M_IDLE);
      chk("done",  done,           m_phase == M_DONE);
      if (m_phase == M_XFER && exp_q.size() > 0) begin
        chk("stream", {sif.sout, sif.sout_par, sif.sout_last, cur_idx}, exp_q[0]);
        if (sif.sout_valid && sif.sout_ready) begin
          if (hs_cnt < 36) cap_bits[hs_cnt] = sif.sout;
          if (sif.sout_last && last_pos < 0) last_pos = hs_cnt;
          hs_cnt++;
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  // ---------------- ready driver ----------------
  int         rdy_mode = 0;
  int         pi = 0;
  logic [3:0] rpat = 4'b1001;

  always @(posedge C) begin
    #1;
    case (rdy_mode)
      1:       begin sif.sout_ready = rpat[pi]; pi = (pi + 1) % 4; end
      2:       sif.sout_ready = 1'($urandom_range(0, 1));
      default: sif.sout_ready = 1'b1;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic clr_cap();
    hs_cnt   = 0;
    cap_bits = '0;
    last_pos = -1;
    done_cyc = -1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    snap_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_phase != M_IDLE && k < 3000) begin step(); k++; end
    chk("idle_timeout", m_phase != M_IDLE, 0);
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_cnt < n && k < 3000) begin step(); k++; end
    chk("hs_timeout", hs_cnt >= n, 1);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (m_phase != ph && k < 3000) begin step(); k++; end
    chk("phase_timeout", m_phase == ph, 1);
  endtask

  // Hand-derived stream for bank {r0=01, r1=A5, r2=FF, r3=00}, bit k = k-th bit sent:
  // r0: 1,0,0,0,0,0,0,0 p1 | r1: 1,0,1,0,0,1,0,1 p0 | r2: 1x8 p0 | r3: 0x8 p0
  logic [35:0]    golden = 36'b000000000_0_11111111_010100101_100000001;
  logic [D*W-1:0] basic_bank = {8'h00, 8'hFF, 8'hA5, 8'h01};

  initial begin
    CLRbar = 1'b0;
    start  = 1'b0;
    bank_q = '0;
    sif.sout_ready = 1'b1;
    clr_cap();
    repeat (3) step();
    CLRbar = 1'b1;
    step();

    // Basic read-out.
    bank_q = basic_bank;
    clr_cap();
    kick();
    wait_idle();
    chk("basic_stream", cap_bits, golden);
    chk("r0_parity", cap_bits[8], 1'b1);
    chk("r1_parity", cap_bits[17], 1'b0);
    chk("r2_parity", cap_bits[26], 1'b0);
    chk("r3_parity", cap_bits[35], 1'b0);
    chk("basic_hs_count", hs_cnt, 36);
    chk("basic_last_pos", last_pos, 35);
    // done observed after edge snap+36, i.e. the 37th cycle after the snapshot.
    chk("basic_done_cycle", done_cyc - snap_cyc, 36);

    // Snapshot isolation: bank goes to all-ones one cycle after start.
    clr_cap();
    kick();
    step();
    bank_q = '1;
    wait_idle();
    chk("snap_iso_stream", cap_bits, golden);
    chk("snap_iso_hs", hs_cnt, 36);
    bank_q = basic_bank;

    // Back-pressure with ready pattern 1,0,0,1.
    rdy_mode = 1;
    clr_cap();
    kick();
    wait_idle();
    chk("bp_stream", cap_bits, golden);
    chk("bp_hs_count", hs_cnt, 36);
    rdy_mode = 0;
    step();

    // start while busy, then start held through DONE.
    clr_cap();
    kick();
    wait_hs(10);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hs(30);
    start = 1'b1;
    wait_phase(M_DONE);
    wait_phase(M_XFER);
    start = 1'b0;
    chk("busy_start_stream", cap_bits, golden);
    chk("busy_start_hs", hs_cnt, 36);
    wait_idle();
    chk("restart_hs_total", hs_cnt, 72);

    // Reset in the middle of a transfer.
    clr_cap();
    kick();
    wait_hs(20);
    @(negedge C);
    #2;
    CLRbar = 1'b0;
    #1;
    chk("async_reset",
        {sif.sout, sif.sout_valid, sif.sout_par, sif.sout_last, cur_idx, busy, done}, 0);
    step();
    step();
    CLRbar = 1'b1;
    repeat (3) step();
    chk("no_done_after_reset", done_cyc < 0, 1'b1);
    clr_cap();
    kick();
    wait_idle();
    chk("post_reset_stream", cap_bits, golden);
    chk("post_reset_hs", hs_cnt, 36);

    // Randomized banks and ready, with bank churn after the snapshot.
    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      bank_q = D*W'($urandom);
      clr_cap();
      kick();
      step();
      bank_q = D*W'($urandom);
      wait_idle();
      chk("rand_hs", hs_cnt, 36);
      chk("rand_last_pos", last_pos, 35);
    end
    rdy_mode = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/reg_bank_reader.md
# reg_bank_reader

Serial read-out engine for a bank of write-enabled register cells. On a start request it snapshots all `DEPTH` registers of `WIDTH` bits in one clock edge, then streams them out bit-serially over a valid/ready handshake, appending an even-parity bit after each register. It is the read side of the register bank: the write side loads cells through their write enables, and this block drains them to a scan/debug port or a serial link.

## Interface
- `WIDTH`, 8, bits per register (≥2)
- `DEPTH`, 4, number of registers in the bank (≥1)

Clock and reset: one clock; reset is asynchronous and active-low (`C` clock, `CLRbar` reset).

- `C`  in  1  clock, rising-edge active
- `CLRbar`  in  1  asynchronous active-low reset
- `start`  in  1  request a read-out; sampled in IDLE only
- `bank_q`  in  DEPTH*WIDTH  parallel register Q outputs; register i at bits [i*WIDTH +: WIDTH]
- `sout`  out  1  serial data bit
- `sout_valid`  out  1  `sout` holds a valid bit
- `sout_ready`  in  1  consumer accepts the bit when `sout_valid & sout_ready`
- `sout_par`  out  1  current bit is a parity bit
- `sout_last`  out  1  current bit is the final bit of the transfer
- `cur_idx`  out  clog2(DEPTH) (min 1)  index of the register being sent
- `busy`  out  1  high from snapshot until `done`
- `done`  out  1  one-cycle pulse after the last bit is accepted

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `start=1` at an edge → snapshot `bank_q` into an internal DEPTH*WIDTH register, `bit_cnt=0`, `cur_idx=0`, go to SHIFT.
- SHIFT: frame per register is WIDTH data bits LSB first, then one parity bit = XOR of the register's WIDTH bits (total ones in frame even). Registers sent in order 0..DEPTH-1.
- Advance only on handshake; `bit_cnt` runs 0..WIDTH, where WIDTH is the parity slot; wraps to 0 and `cur_idx` increments after the parity bit.
- After the handshake on the parity bit of register DEPTH-1 → DONE.
- DONE: `done=1`, `busy=1` for exactly one cycle → IDLE.
- `start` ignored outside IDLE; `start` held high across DONE→IDLE begins a new transfer on the next edge in IDLE.
- Changes on `bank_q` after the snapshot edge do not affect the output stream.
- `sout_last=1` only on the final parity bit; `sout_par=1` on every parity slot.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `sout=0`, `sout_valid=0`, `sout_par=0`, `sout_last=0`, `cur_idx=0`, `busy=0`, `done=0`; snapshot cleared to 0.
- Reset asserted mid-transfer aborts immediately; no `done` pulse is produced.
- Latency: `start` sampled at edge N → `sout_valid=1` with data bit 0 of register 0 during cycle N+1.
- One bit per cycle at most; with `sout_ready` held high a transfer takes DEPTH*(WIDTH+1) cycles and `done` is high in the cycle after the last handshake.
- Stall: while `sout_valid & !sout_ready`, the outputs `sout`, `sout_par`, `sout_last` and `cur_idx` hold stable.
- `sout_valid` is never withdrawn without a handshake until the transfer ends.
- All outputs are registered.

## Structure
- Shared package: state encoding (IDLE=0, SHIFT=1, DONE=2), and the bit-count and index width helpers derived from `WIDTH`/`DEPTH`.
- One natural sub-module, `frame_serializer`: takes one WIDTH-bit word, emits WIDTH bits plus parity under the handshake, and signals end-of-frame. The top level owns the snapshot, `cur_idx` and the FSM.

## Test plan
- Reset: drive `CLRbar=0` mid-cycle → all outputs 0 immediately, with no clock edge.
- Basic read-out with WIDTH=8, DEPTH=4, bank {r0=0x01, r1=0xA5, r2=0xFF, r3=0x00}, `sout_ready=1`:
  - r0 stream → 1,0,0,0,0,0,0,0, parity 1
  - r1 stream → 1,0,1,0,0,1,0,1, parity 0
  - r2 parity → 0; r3 parity → 0
  - 36 handshakes; `sout_last` on the 36th; `done` in cycle 37 after the snapshot.
- Snapshot isolation: change `bank_q` to all-ones one cycle after `start` → stream still matches the original snapshot.
- Back-pressure: toggle `sout_ready` 1,0,0,1 repeatedly → `sout` stable during stalls; stream identical to the unstalled case; length equals 36 handshakes.
- `start` while busy: pulse `start` at bit 10 → no restart and no disturbance; holding `start` high through DONE → new transfer, valid 1 cycle after return to IDLE.
- Reset at bit 20 of a transfer: `CLRbar` low → outputs 0, no `done`; a fresh `start` afterwards → full 36-bit stream from r0 bit 0.
